// File: rtl/elastic_fifo.sv
// Multi-entry elastic buffer: valid/ready on the enqueue side, valid/yumi on the
// dequeue side, first-word fall-through head, occupancy count and synchronous flush.
module elastic_fifo #(
    parameter int width_p = 10,
    parameter int depth_p = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         clear_i,
    input  logic [width_p-1:0]           data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic                         valid_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         yumi_i,
    output logic [$clog2(depth_p+1)-1:0] count_o
);

    localparam int ptr_w_lp = $clog2(depth_p);
    localparam int cnt_w_lp = $clog2(depth_p + 1);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(depth_p - 1);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(depth_p);

    logic [width_p-1:0]  mem [depth_p];
    logic [ptr_w_lp-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ptr_w_lp-1:0] wr_ptr_reg, wr_ptr_next;
    logic [cnt_w_lp-1:0] count_reg, count_next;
    logic                enq, deq;

    // Explicit wrap so that non-power-of-two depths index correctly.
    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign enq = valid_i & ready_o;
    assign deq = yumi_i & valid_o;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (clear_i) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (enq) wr_ptr_next = ptr_inc(wr_ptr_reg);
            if (deq) rd_ptr_next = ptr_inc(rd_ptr_reg);
            case ({enq, deq})
                2'b10:   count_next = count_reg + cnt_w_lp'(1);
                2'b01:   count_next = count_reg - cnt_w_lp'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is never reset; a flushed write is harmless but suppressed anyway.
    always_ff @(posedge clk_i) begin
        if (enq && !clear_i) mem[wr_ptr_reg] <= data_i;
    end

    assign ready_o = (count_reg != full_cnt_lp);
    assign valid_o = (count_reg != '0);
    assign data_o  = mem[rd_ptr_reg];
    assign count_o = count_reg;

endmodule

// File: tb/tb_elastic_fifo.sv
// Bench for elastic_fifo: depth-4 and depth-3 instances share one stimulus stream
// and are each checked every cycle against a queue model of the buffer.
module tb_elastic_fifo;

    logic       clk_i = 1'b0;
    logic       reset_i, clear_i, valid_i, yumi_i;
    logic [9:0] data_i;
    logic       ready4, valid4, ready3, valid3;
    logic [9:0] data4, data3;
    logic [2:0] count4;
    logic [1:0] count3;

    always #5 clk_i = ~clk_i;

    elastic_fifo #(.width_p(10), .depth_p(4)) u_dut4 (
        .clk_i(clk_i), .reset_i(reset_i), .clear_i(clear_i), .data_i(data_i),
        .valid_i(valid_i), .ready_o(ready4), .valid_o(valid4), .data_o(data4),
        .yumi_i(yumi_i), .count_o(count4)
    );

    elastic_fifo #(.width_p(10), .depth_p(3)) u_dut3 (
        .clk_i(clk_i), .reset_i(reset_i), .clear_i(clear_i), .data_i(data_i),
        .valid_i(valid_i), .ready_o(ready3), .valid_o(valid3), .data_o(data3),
        .yumi_i(yumi_i), .count_o(count3)
    );

    logic [9:0] q4[$];
    logic [9:0] q3[$];
    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock of stimulus; the models decide what fires from pre-edge occupancy.
    task automatic step(input logic v, input logic [9:0] d, input logic y, input logic c);
        bit e4, p4, e3, p3;
        valid_i = v; data_i = d; yumi_i = y; clear_i = c;
        e4 = v && (q4.size() < 4);
        p4 = y && (q4.size() > 0);
        e3 = v && (q3.size() < 3);
        p3 = y && (q3.size() > 0);
        @(posedge clk_i);
        if (!reset_i) begin
            if (c) begin
                q4.delete();
                q3.delete();
            end else begin
                if (p4) void'(q4.pop_front());
                if (e4) q4.push_back(d);
                if (p3) void'(q3.pop_front());
                if (e3) q3.push_back(d);
            end
        end
        @(negedge clk_i);
        $display("cycle: v=%0b d=0x%03h y=%0b c=%0b -> count4=%0d count3=%0d", v, d, y, c, count4, count3);
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("ready4", 32'(ready4), 32'(q4.size() != 4));
            chk("valid4", 32'(valid4), 32'(q4.size() != 0));
            chk("count4", 32'(count4), 32'(q4.size()));
            if (q4.size() > 0) chk("data4", 32'(data4), 32'(q4[0]));
            chk("ready3", 32'(ready3), 32'(q3.size() != 3));
            chk("valid3", 32'(valid3), 32'(q3.size() != 0));
            chk("count3", 32'(count3), 32'(q3.size()));
            if (q3.size() > 0) chk("data3", 32'(data3), 32'(q3[0]));
        end
    end

    initial begin
        int delivered;
        int popped;
        int pushed;
        logic v, y;
        bit acc, pop;

        reset_i = 1'b0; clear_i = 1'b0; valid_i = 1'b0; yumi_i = 1'b0; data_i = '0;
        #1 reset_i = 1'b1;
        #1;
        chk("rst_valid", 32'(valid4), 32'd0);
        chk("rst_ready", 32'(ready4), 32'd1);
        chk("rst_count", 32'(count4), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        chk_en = 1'b1;
        repeat (3) step(1'b0, 10'h000, 1'b0, 1'b0);
        chk("idle_count", 32'(count4), 32'd0);

        // Fill, overfill, drain
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 10'(i), 1'b0, 1'b0);
            chk("fill_count", 32'(count4), 32'(i));
        end
        chk("full_ready", 32'(ready4), 32'd0);
        step(1'b1, 10'h005, 1'b0, 1'b0);
        chk("overfill_count", 32'(count4), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", 32'(data4), 32'(i));
            step(1'b0, 10'h000, 1'b1, 1'b0);
        end
        chk("drained_valid", 32'(valid4), 32'd0);
        chk("drained_count", 32'(count4), 32'd0);

        // Full plus yumi: only the dequeue fires, ready returns next cycle
        for (int i = 1; i <= 4; i++) step(1'b1, 10'(12'h40 + i), 1'b0, 1'b0);
        step(1'b1, 10'h050, 1'b1, 1'b0);
        chk("fullyumi_count", 32'(count4), 32'd3);
        chk("fullyumi_ready", 32'(ready4), 32'd1);
        step(1'b1, 10'h051, 1'b0, 1'b0);
        chk("refill_count", 32'(count4), 32'd4);
        repeat (5) step(1'b0, 10'h000, 1'b1, 1'b0);

        // Streaming at one word per cycle
        delivered = 0;
        for (int i = 0; i < 20; i++) begin
            y = valid4;
            if (y) delivered++;
            step(1'b1, 10'(12'h100 + i), y, 1'b0);
            chk("stream_count", 32'(count4), 32'd1);
            chk("stream_lag", 32'(data4), 32'(12'h100 + i));
        end
        chk("stream_delivered", 32'(delivered), 32'd19);
        repeat (2) step(1'b0, 10'h000, 1'b1, 1'b0);

        // Random gaps, 10 words through the depth-3 instance
        popped = 0;
        pushed = 0;
        for (int k = 0; k < 400 && popped < 10; k++) begin
            v = (pushed < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
            y = 1'($urandom_range(0, 1));
            acc = v && (q3.size() < 3);
            pop = y && (q3.size() > 0);
            step(v, 10'(12'h300 + pushed), y, 1'b0);
            if (acc) pushed++;
            if (pop) popped++;
        end
        chk("wrap_popped", 32'(popped), 32'd10);
        repeat (6) step(1'b0, 10'h000, 1'b1, 1'b0);

        // Clear beats a same-cycle push and pop
        for (int i = 1; i <= 3; i++) step(1'b1, 10'(12'h2A0 + i), 1'b0, 1'b0);
        step(1'b1, 10'h2AA, 1'b1, 1'b1);
        chk("clear_count", 32'(count4), 32'd0);
        chk("clear_valid", 32'(valid4), 32'd0);
        chk("clear_count3", 32'(count3), 32'd0);

        // Asynchronous reset mid-stream
        step(1'b1, 10'h0A1, 1'b0, 1'b0);
        step(1'b1, 10'h0A2, 1'b0, 1'b0);
        valid_i = 1'b0;
        #2 reset_i = 1'b1;
        q4.delete();
        q3.delete();
        #1;
        chk("midrst_valid", 32'(valid4), 32'd0);
        chk("midrst_ready", 32'(ready4), 32'd1);
        chk("midrst_count", 32'(count4), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        step(1'b1, 10'h3FF, 1'b0, 1'b0);
        chk("postrst_count", 32'(count4), 32'd1);
        chk("postrst_data", 32'(data4), 32'h3FF);
        step(1'b0, 10'h000, 1'b1, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
